// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Imported by the top and the priority picker.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic {OP_RD, OP_WR} arb_op_t;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    // Index width that stays legal (>=1 bit) for any port count.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational picker: first set request searching upward from base, wrapping to 0.
// Tying base to zero gives plain fixed priority (lowest index wins).
module rr_priority_picker
    import arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int            pos;
    logic [IW-1:0] pos_idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(base) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (!valid && req[pos_idx]) begin
                valid = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_PORTS requesters onto one memory port, one transaction outstanding at a time.
// The winning request is captured at grant; the memory side is driven only from those registers.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MODE      = ARB_MODE_RR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_read,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_mbe,
    output logic [NUM_PORTS-1:0]          req_resp,
    output logic [DATA_W-1:0]             req_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_mbe,
    input  logic                          mem_resp,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          proto_err
);

    localparam int IW    = idx_width(NUM_PORTS);
    localparam int MBE_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    arb_op_t           op_q, op_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MBE_W-1:0]  mbe_q, mbe_d;
    logic              proto_err_q, proto_err_d;

    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
    logic [MBE_W-1:0]  mbe_arr   [NUM_PORTS];

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] pick_base;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
            mbe_arr[i]   = req_mbe[i*MBE_W +: MBE_W];
        end
    end

    assign pick_base = (MODE == ARB_MODE_RR) ? rr_ptr_q : '0;

    rr_priority_picker #(.N(NUM_PORTS)) u_picker (
        .req   (req_read | req_write),
        .base  (pick_base),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mbe_d       = mbe_q;
        proto_err_d = proto_err_q;
        req_resp    = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    mbe_d   = mbe_arr[pick_idx];
                    // Read+write together is served as a write and flagged.
                    op_d    = req_write[pick_idx] ? OP_WR : OP_RD;
                    if (req_read[pick_idx] && req_write[pick_idx]) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                    // A completion racing with reset is dropped, not forwarded.
                    req_resp[grant_q] = !reset;
                    if (MODE == ARB_MODE_RR) begin
                        rr_ptr_d = (grant_q == IW'(NUM_PORTS - 1)) ? '0 : grant_q + IW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q     <= ARB_IDLE;
            op_q        <= OP_RD;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mbe_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mbe_q       <= mbe_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_read  = (state_q == ARB_BUSY) && (op_q == OP_RD);
    assign mem_write = (state_q == ARB_BUSY) && (op_q == OP_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_mbe   = mbe_q;
    assign req_rdata = mem_rdata;
    assign proto_err = proto_err_q;

endmodule
